// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: mult/div opcodes and
// the busy-interlock FSM states.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_fsm.sv
// Mult/div latency interlock: holds md_busy for exactly the op latency, then
// pulses md_done for one cycle. Starts while busy are dropped and flagged.
module pipe_stall_ctrl_md_busy_fsm
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       md_start_E,
    input  logic [1:0] md_op_E,
    output logic       md_busy,
    output logic       md_done,
    output logic       err_overlap
);

    localparam int CW = $clog2(lat_max(MULT_LAT, DIV_LAT) + 1);

    md_state_e     state;
    logic [CW-1:0] count;
    logic          is_div;

    assign is_div = md_op_e'(md_op_E) inside {MD_DIV, MD_DIVU};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            count       <= '0;
            md_busy     <= 1'b0;
            md_done     <= 1'b0;
            err_overlap <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (md_start_E) begin
                        state   <= S_BUSY;
                        count   <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
                        md_busy <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (md_start_E)
                        err_overlap <= 1'b1;
                    // Final busy cycle: result lands in HI/LO on this edge.
                    if (count == CW'(1)) begin
                        state   <= S_IDLE;
                        count   <= '0;
                        md_busy <= 1'b0;
                        md_done <= 1'b1;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    count   <= '0;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Merges hazard-unit stall with the mult/div busy interlock into PC / IF-ID
// enables and ID/EX bubble insert; counts stalled cycles (saturating).
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stop,
    input  logic             md_start_E,
    input  logic [1:0]       md_op_E,
    input  logic             md_use_D,
    output logic             en_PC,
    output logic             en_D,
    output logic             clr_E,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_overlap
);

    logic md_stall;
    logic stall;

    pipe_stall_ctrl_md_busy_fsm #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_fsm (
        .clk         (clk),
        .reset       (reset),
        .md_start_E  (md_start_E),
        .md_op_E     (md_op_E),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .err_overlap (err_overlap)
    );

    // A D-stage HI/LO consumer must wait while the unit is busy or being started.
    assign md_stall = md_use_D & (md_busy | md_start_E);
    assign stall    = stop | md_stall;

    assign en_PC = ~stall;
    assign en_D  = ~stall;
    assign clr_E = stall;

    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: reset, plain stall, mult/div interlock,
// back-to-back, overlap error, mid-op reset and counter saturation.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset, stop, md_start_E, md_use_D;
    logic [1:0]  md_op_E;
    logic        en_PC, en_D, clr_E, md_busy, md_done, err_overlap;
    logic [31:0] stall_cnt;

    logic        reset_s, stop_s;
    logic        en_PC_s, en_D_s, clr_E_s, md_busy_s, md_done_s, err_s;
    logic [3:0]  stall_cnt_s;
    logic        zero_s = 1'b0;
    logic [1:0]  op_s = 2'b00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk(clk), .reset(reset), .stop(stop), .md_start_E(md_start_E),
        .md_op_E(md_op_E), .md_use_D(md_use_D), .en_PC(en_PC), .en_D(en_D),
        .clr_E(clr_E), .md_busy(md_busy), .md_done(md_done),
        .stall_cnt(stall_cnt), .err_overlap(err_overlap)
    );

    pipe_stall_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset_s), .stop(stop_s), .md_start_E(zero_s),
        .md_op_E(op_s), .md_use_D(zero_s), .en_PC(en_PC_s), .en_D(en_D_s),
        .clr_E(clr_E_s), .md_busy(md_busy_s), .md_done(md_done_s),
        .stall_cnt(stall_cnt_s), .err_overlap(err_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stop = 1'b1; md_start_E = 1'b1; md_op_E = 2'b00; md_use_D = 1'b0;
        step(); step();
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", md_busy); end
        n_checks++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", md_done); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
        n_checks++; if (err_overlap !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err_overlap); end
        n_checks++; if ({en_PC, en_D, clr_E} !== 3'b001) begin n_fail++; $display("FAIL rst_en got=%b exp=001", {en_PC, en_D, clr_E}); end
        stop = 1'b0; md_start_E = 1'b0;
        #1;
        n_checks++; if ({en_PC, en_D, clr_E} !== 3'b110) begin n_fail++; $display("FAIL rst_idle_en got=%b exp=110", {en_PC, en_D, clr_E}); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_plain_stall();
        for (int i = 0; i < 3; i++) begin
            stop = 1'b1;
            #1;
            n_checks++; if ({en_PC, en_D, clr_E} !== 3'b001) begin n_fail++; $display("FAIL stall_en[%0d] got=%b exp=001", i, {en_PC, en_D, clr_E}); end
            step();
        end
        stop = 1'b0;
        #1;
        n_checks++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
        n_checks++; if (en_PC !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", en_PC); end
    endtask

    // Busy interlock with a consumer in D; stop overlaps one busy cycle.
    task automatic test_mult();
        md_start_E = 1'b1; md_op_E = 2'b00;
        #1;
        n_checks++; if (en_PC !== 1'b1) begin n_fail++; $display("FAIL mult_start_nouse got=%b exp=1", en_PC); end
        step();
        md_start_E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            md_use_D = 1'b1;
            stop = (i == 2);
            #1;
            n_checks++; if ({md_busy, md_done} !== 2'b10) begin n_fail++; $display("FAIL mult_busy[%0d] got=%b exp=10", i, {md_busy, md_done}); end
            n_checks++; if ({en_PC, clr_E} !== 2'b01) begin n_fail++; $display("FAIL mult_stall[%0d] got=%b exp=01", i, {en_PC, clr_E}); end
            step();
        end
        stop = 1'b0;
        #1;
        n_checks++; if ({md_busy, md_done} !== 2'b01) begin n_fail++; $display("FAIL mult_done got=%b exp=01", {md_busy, md_done}); end
        n_checks++; if (en_PC !== 1'b1) begin n_fail++; $display("FAIL mult_release got=%b exp=1", en_PC); end
        n_checks++; if (stall_cnt !== 32'd8) begin n_fail++; $display("FAIL mult_cnt got=%0d exp=8", stall_cnt); end
        md_use_D = 1'b0;
        step();
        n_checks++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse got=%b exp=0", md_done); end
    endtask

    task automatic test_back_to_back();
        md_start_E = 1'b1; md_op_E = 2'b10;
        step();
        md_start_E = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if ({md_busy, md_done} !== 2'b10) begin n_fail++; $display("FAIL div1_busy[%0d] got=%b exp=10", i, {md_busy, md_done}); end
            step();
        end
        n_checks++; if ({md_busy, md_done} !== 2'b01) begin n_fail++; $display("FAIL div1_done got=%b exp=01", {md_busy, md_done}); end
        md_start_E = 1'b1; md_op_E = 2'b11;
        step();
        md_start_E = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if ({md_busy, md_done} !== 2'b10) begin n_fail++; $display("FAIL div2_busy[%0d] got=%b exp=10", i, {md_busy, md_done}); end
            step();
        end
        n_checks++; if ({md_busy, md_done} !== 2'b01) begin n_fail++; $display("FAIL div2_done got=%b exp=01", {md_busy, md_done}); end
        n_checks++; if (err_overlap !== 1'b0) begin n_fail++; $display("FAIL b2b_err got=%b exp=0", err_overlap); end
        n_checks++; if (stall_cnt !== 32'd8) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=8", stall_cnt); end
        step();
    endtask

    task automatic test_overlap();
        int nb;
        int nd;
        nb = 0; nd = 0;
        md_start_E = 1'b1; md_op_E = 2'b01;
        step();
        for (int i = 0; i < 12; i++) begin
            if (md_busy === 1'b1) nb++;
            if (md_done === 1'b1) nd++;
            md_start_E = (i == 1);
            md_op_E = 2'b10;
            step();
        end
        md_start_E = 1'b0;
        n_checks++; if (nb !== 5) begin n_fail++; $display("FAIL ovl_busy_len got=%0d exp=5", nb); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL ovl_done_cnt got=%0d exp=1", nd); end
        n_checks++; if (err_overlap !== 1'b1) begin n_fail++; $display("FAIL ovl_err got=%b exp=1", err_overlap); end
        step(); step();
        n_checks++; if (err_overlap !== 1'b1) begin n_fail++; $display("FAIL ovl_sticky got=%b exp=1", err_overlap); end
    endtask

    task automatic test_reset_mid_op();
        int nd;
        nd = 0;
        md_start_E = 1'b1; md_op_E = 2'b10;
        step();
        md_start_E = 1'b0;
        step(); step();
        n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre got=%b exp=1", md_busy); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_checks++; if ({md_busy, md_done, err_overlap} !== 3'b000) begin n_fail++; $display("FAIL mid_rst got=%b exp=000", {md_busy, md_done, err_overlap}); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_cnt got=%0d exp=0", stall_cnt); end
        for (int i = 0; i < 15; i++) begin
            if (md_done === 1'b1 || md_busy === 1'b1) nd++;
            step();
        end
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL mid_no_done got=%0d exp=0", nd); end
    endtask

    task automatic test_saturation();
        reset_s = 1'b0; stop_s = 1'b0;
        step();
        reset_s = 1'b1; stop_s = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) begin
                n_checks++; if (stall_cnt_s !== 4'd14) begin n_fail++; $display("FAIL sat_14 got=%0d exp=14", stall_cnt_s); end
            end
            if (i == 15) begin
                n_checks++; if (stall_cnt_s !== 4'd15) begin n_fail++; $display("FAIL sat_15 got=%0d exp=15", stall_cnt_s); end
            end
        end
        n_checks++; if (stall_cnt_s !== 4'd15) begin n_fail++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt_s); end
        stop_s = 1'b0;
    endtask

    initial begin
        reset_s = 1'b0; stop_s = 1'b0;
        test_reset();
        test_plain_stall();
        test_mult();
        test_back_to_back();
        test_overlap();
        test_reset_mid_op();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
